register_bank_multimode: RTL and testbench

//  Parametrised successor to the single flip-flop register: a bank of NrOfRegs

---
 rtl/register_bank_multimode.sv | 120 ++++++++++++
 tb/tb_register_bank_multimode.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/register_bank_multimode.sv
// Bank of NrOfRegs registers with per-cycle hold/load/shift-left/increment ops and a tri-stateable read port.
// Define REG_BANK_SATURATE_EN to make increment saturate at all-ones instead of wrapping.
module register_bank_multimode #(
  parameter int NrOfBits = 8,
  parameter int NrOfRegs = 4,
  parameter int AddrBits = 2,
  parameter logic [NrOfBits-1:0] ResetValue = '0
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                ClockEnable,
  input  logic                Tick,
  input  logic                pre,
  input  logic [AddrBits-1:0] Sel,
  input  logic [1:0]          Mode,
  input  logic [NrOfBits-1:0] D,
  input  logic                ShiftIn,
  input  logic [AddrBits-1:0] RdSel,
  input  logic                cs,
  output logic [NrOfBits-1:0] Q,
  output logic                CarryOut,
  output logic                Zero
);

  typedef enum logic [1:0] {
    MODE_HOLD  = 2'b00,
    MODE_LOAD  = 2'b01,
    MODE_SHIFT = 2'b10,
    MODE_INCR  = 2'b11
  } mode_t;

  logic [NrOfBits-1:0] regs [NrOfRegs];
  logic [NrOfBits-1:0] sel_val;
  logic [NrOfBits-1:0] rd_val;
  logic [NrOfBits-1:0] next_val;
  logic                next_carry;
  logic                do_write;
  logic                sel_valid;
  logic                op_en;
  mode_t               mode;

  assign mode  = mode_t'(Mode);
  assign op_en = ClockEnable & Tick;

  // Out-of-range selects match no register, so they fall through to "no write".
  always_comb begin
    sel_val   = '0;
    sel_valid = 1'b0;
    rd_val    = '0;
    for (int i = 0; i < NrOfRegs; i++) begin
      if (32'(Sel) == i) begin
        sel_val   = regs[i];
        sel_valid = 1'b1;
      end
      if (32'(RdSel) == i) begin
        rd_val = regs[i];
      end
    end
  end

  always_comb begin
    next_val   = sel_val;
    next_carry = CarryOut;
    do_write   = 1'b0;
    if (pre) begin
      next_val   = '1;
      next_carry = 1'b0;
      do_write   = sel_valid;
    end else if (op_en) begin
      case (mode)
        MODE_LOAD: begin
          next_val   = D;
          next_carry = 1'b0;
          do_write   = sel_valid;
        end
        MODE_SHIFT: begin
          next_val    = sel_val << 1;
          next_val[0] = ShiftIn;
          next_carry  = sel_val[NrOfBits-1];
          do_write    = sel_valid;
        end
        MODE_INCR: begin
`ifdef REG_BANK_SATURATE_EN
          next_val   = (&sel_val) ? sel_val : sel_val + NrOfBits'(1);
`else
          next_val   = sel_val + NrOfBits'(1);
`endif
          next_carry = &sel_val;
          do_write   = sel_valid;
        end
        default: begin
          next_val   = sel_val;
          next_carry = CarryOut;
          do_write   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int i = 0; i < NrOfRegs; i++) begin
        regs[i] <= ResetValue;
      end
      CarryOut <= 1'b0;
    end else if (do_write) begin
      for (int i = 0; i < NrOfRegs; i++) begin
        if (32'(Sel) == i) begin
          regs[i] <= next_val;
        end
      end
      CarryOut <= next_carry;
    end
  end

  // Unmapped read addresses read as zero so Zero reports 1 for them.
  assign Q    = cs ? {NrOfBits{1'bz}} : rd_val;
  assign Zero = cs ? 1'b0 : (rd_val == '0);

endmodule

// File: tb/tb_register_bank_multimode.sv
// Randomized self-checking bench for register_bank_multimode against an arithmetic reference model.
module tb_register_bank_multimode;

  localparam int NB = 8;
  localparam int NR = 4;
  localparam int AB = 3;

  logic          Clock = 1'b0;
  logic          Reset = 1'b1;
  logic          ClockEnable = 1'b0;
  logic          Tick = 1'b0;
  logic          pre = 1'b0;
  logic [AB-1:0] Sel = '0;
  logic [1:0]    Mode = '0;
  logic [NB-1:0] D = '0;
  logic          ShiftIn = 1'b0;
  logic [AB-1:0] RdSel = '0;
  logic          cs = 1'b0;
  logic [NB-1:0] Q;
  logic          CarryOut;
  logic          Zero;

  int checkCount = 0;
  int errorCount = 0;
  int model [NR];
  int modelCarry = 0;

  register_bank_multimode #(
    .NrOfBits(NB), .NrOfRegs(NR), .AddrBits(AB), .ResetValue(8'h00)
  ) dut (
    .Clock(Clock), .Reset(Reset), .ClockEnable(ClockEnable), .Tick(Tick),
    .pre(pre), .Sel(Sel), .Mode(Mode), .D(D), .ShiftIn(ShiftIn),
    .RdSel(RdSel), .cs(cs), .Q(Q), .CarryOut(CarryOut), .Zero(Zero)
  );

  always #10 Clock = ~Clock;

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checkCount++;
    if (obs !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour of one rising edge, using the inputs currently applied.
  task automatic modelEdge();
    int s;
    s = int'(Sel);
    if (Reset) begin
      for (int i = 0; i < NR; i++) model[i] = 0;
      modelCarry = 0;
    end else if (s < NR) begin
      if (pre) begin
        model[s] = 255;
        modelCarry = 0;
      end else if (ClockEnable && Tick) begin
        case (Mode)
          2'd1: begin model[s] = int'(D); modelCarry = 0; end
          2'd2: begin
            modelCarry = model[s] / 128;
            model[s] = (model[s] * 2 + int'(ShiftIn)) % 256;
          end
          2'd3: begin
            modelCarry = (model[s] == 255) ? 1 : 0;
`ifdef REG_BANK_SATURATE_EN
            if (model[s] != 255) model[s] = model[s] + 1;
`else
            model[s] = (model[s] + 1) % 256;
`endif
          end
          default: ;
        endcase
      end
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic pr, input logic ce, input logic tk,
                               input int sel, input int md, input int dat, input logic si);
    Reset = rst; pre = pr; ClockEnable = ce; Tick = tk;
    Sel = AB'(sel); Mode = 2'(md); D = NB'(dat); ShiftIn = si;
    modelEdge();
    @(posedge Clock);
    #1;
  endtask

  task automatic checkAll(input string tag);
    cs = 1'b0;
    for (int i = 0; i < NR; i++) begin
      RdSel = AB'(i);
      #1;
      checkOutput({tag, "_q"}, 16'(Q), 16'(model[i]));
      checkOutput({tag, "_zero"}, 16'(Zero), 16'(model[i] == 0));
    end
    RdSel = AB'(5);
    #1;
    checkOutput({tag, "_q_oor"}, 16'(Q), 16'h0);
    checkOutput({tag, "_zero_oor"}, 16'(Zero), 16'h1);
    cs = 1'b1;
    #1;
    checkOutput({tag, "_zero_cs"}, 16'(Zero), 16'h0);
    cs = 1'b0;
    checkOutput({tag, "_carry"}, 16'(CarryOut), 16'(modelCarry));
  endtask

  task automatic checkReg(input string tag, input int idx, input int exp, input int expCarry);
    RdSel = AB'(idx);
    cs = 1'b0;
    #1;
    checkOutput({tag, "_q"}, 16'(Q), 16'(exp));
    checkOutput({tag, "_carry"}, 16'(CarryOut), 16'(expCarry));
  endtask

  initial begin
    for (int i = 0; i < NR; i++) model[i] = 0;

    // Reset wins over a pending load.
    applyStimulus(1, 0, 1, 1, 2, 1, 'hAA, 0);
    checkAll("reset");
    checkReg("reset_r2", 2, 'h00, 0);

    // Shift-left sequence on reg1.
    applyStimulus(0, 0, 1, 1, 1, 1, 'h81, 0);
    applyStimulus(0, 0, 1, 1, 1, 2, 0, 1);
    checkReg("shift1", 1, 'h03, 1);
    applyStimulus(0, 0, 1, 1, 1, 2, 0, 1);
    checkReg("shift2", 1, 'h07, 0);
    checkAll("shift");

    // Increment across the all-ones boundary on reg3.
    applyStimulus(0, 0, 1, 1, 3, 1, 'hFE, 0);
    applyStimulus(0, 0, 1, 1, 3, 3, 0, 0);
    checkReg("incr1", 3, 'hFF, 0);
    applyStimulus(0, 0, 1, 1, 3, 3, 0, 0);
`ifdef REG_BANK_SATURATE_EN
    checkReg("incr2", 3, 'hFF, 1);
`else
    checkReg("incr2", 3, 'h00, 1);
`endif
    applyStimulus(0, 0, 1, 1, 3, 3, 0, 0);
`ifdef REG_BANK_SATURATE_EN
    checkReg("incr3", 3, 'hFF, 1);
`else
    checkReg("incr3", 3, 'h01, 0);
`endif
    checkAll("incr");

    // No tick means no change; out-of-range select is ignored.
    for (int k = 0; k < 5; k++) applyStimulus(0, 0, 1, 0, 3, 3, 0, 0);
    checkAll("notick");
    applyStimulus(0, 0, 1, 1, 5, 1, 'h55, 0);
    checkAll("oor_sel");

    // Preset ignores enable; reset beats preset.
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
    checkReg("pre", 0, 'hFF, 0);
    applyStimulus(1, 1, 1, 1, 0, 1, 'h12, 0);
    checkAll("pre_reset");

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      applyStimulus(($urandom_range(0, 19) == 0), ($urandom_range(0, 9) == 0),
                    1'($urandom), ($urandom_range(0, 3) != 0),
                    int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 255)), 1'($urandom));
      checkAll("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
